ts_dc_symbol_inserter: RTL and testbench
========================================

Name: ts_dc_symbol_inserter

Overview:
- Per-lane Gen3+ TX stage directly downstream of the lane scrambler. It consumes the symb_14/symb_15 DC-balance codes produced by the running DC-balance tracker.
- Tracks the symbol index inside each 16-symbol ordered set and drives the index and TS qualifier back to the tracker.
- Substitutes TS1/TS2 symbols 14 and 15 with 20h, DFh or the normal TS identifier; all other symbols pass through.
- Output is registered and feeds the lane serializer/PIPE interface.

Parameters:
- DATA_WIDTH, 8, symbol width.
- COUNT_WIDTH, 4, symbol-index width.
- OS_LEN, 16, symbols per ordered set.
- TS1_ID, 8'h4A, normal TS1 symbol 14/15 value.
- TS2_ID, 8'h45, normal TS2 symbol 14/15 value.
- DCB_LOW, 8'h20, sent when code 2'b00 (too many ones).
- DCB_HIGH, 8'hDF, sent when code 2'b01 (too many zeros).

Ports:
- clk  in  1  symbol clock.
- rst  in  1  asynchronous active-low reset.
- sc_data_in  in  DATA_WIDTH  scrambled symbol from scrambler.
- sc_valid  in  1  sc_data_in valid this cycle.
- os_start  in  1  sc_data_in is symbol 0 of an ordered set (qualified by sc_valid).
- ts_type  in  2  sampled with os_start: 00 non-TS OS, 01 TS1, 10 TS2, 11 reserved (treated as 00).
- symb_14_code  in  2  from DC-balance tracker: 00 low, 01 high, 10 normal, 11 treated as 10.
- symb_15_code  in  2  same encoding, for symbol 15.
- sym_count  out  COUNT_WIDTH  index of the current input symbol, to tracker.
- ts_flag  out  1  current input symbol belongs to a TS1/TS2, to tracker.
- data_out  out  DATA_WIDTH  registered output symbol.
- data_out_valid  out  1  data_out valid.
- os_done  out  1  one-cycle pulse with the registered symbol 15 of any ordered set.
- os_err  out  1  one-cycle pulse: os_start arrived before the previous OS completed.

Behaviour:
- Reset (rst=0, async): state=IDLE, index=0, latched type=00. data_out=0, data_out_valid=0, os_done=0, os_err=0. sym_count=0 and ts_flag=0 (both combinational from state).
- FSM states are IDLE, TS_BODY and OS_BODY. Only cycles with sc_valid=1 advance the FSM. sc_valid=0 holds all state, and data_out_valid drops to 0 the next cycle.
- IDLE:
  - sc_valid & os_start & ts_type in {01,10} -> TS_BODY.
  - sc_valid & os_start & other ts_type -> OS_BODY.
  - Either way, index becomes 1 after the symbol and ts_type is latched.
  - sc_valid without os_start: data symbol, passed through; index stays 0.
- TS_BODY / OS_BODY: each valid symbol increments index. The symbol at index OS_LEN-1 returns the FSM to IDLE and index to 0, and pulses os_done with that symbol's output.
- os_start while in a BODY state: os_err pulses (registered, aligned with data_out). The current OS is abandoned and the FSM restarts at index 1 in the state selected by the new ts_type; the symbol itself is treated as symbol 0.
- sym_count = index of the symbol currently on sc_data_in. It is 0 on an os_start cycle, including the restart case.
- ts_flag = 1 when (state==TS_BODY) or (IDLE/BODY & os_start & sc_valid & ts_type in {01,10}).
- Substitution applies only to TS symbols:
  - Index 14: value from symb_14_code, sampled the same cycle (00->DCB_LOW, 01->DCB_HIGH, else TS1_ID/TS2_ID per latched type).
  - Index 15: value from symb_15_code, sampled the same cycle.
  - These substituted symbols are not scrambled; sc_data_in is ignored for them.
- All other symbols: data_out = sc_data_in.
- Latency: exactly 1 cycle, sc_valid -> data_out_valid. No backpressure.
- Index arithmetic is modulo OS_LEN; it never wraps past OS_LEN-1 without returning to IDLE.

Decomposition:
- Shared package pcie_os_pkg holds:
  - ts_type_e (NON_TS, TS1, TS2).
  - dcb_code_e (DCB_LOW_C=00, DCB_HIGH_C=01, DCB_NORM_C=10).
  - Symbol constants TS1_ID, TS2_ID, DCB_LOW, DCB_HIGH, OS_LEN.
- One sub-module, os_symbol_counter: FSM, index, ts_flag, os_err. The top holds the substitution mux and output registers.

Test Plan:
1. TS1, 16 valid symbols 00h..0Fh, codes 10/10 -> outputs 00h..0Dh, 4Ah, 4Ah; os_done with the 16th output; sym_count 0..15; ts_flag=1 throughout.
2. TS2 with symb_14_code=00, symb_15_code=01 -> out sym14=20h, sym15=DFh; sym13 passes 0Dh unchanged.
3. Non-TS OS (ts_type=00), codes 00/00, input sym14/15=AAh -> AAh, AAh passed; ts_flag=0; os_done still pulses.
4. TS1 with sc_valid=0 for 3 cycles after symbol 7 -> index holds at 8, data_out_valid low 3 cycles, final sym14/15 still substituted at index 14/15.
5. os_start at index 9 of a TS1 -> os_err pulse aligned with that output; sym_count=0 that cycle; new OS completes 16 symbols later with os_done.
6. rst asserted at index 12 -> all outputs 0 immediately; after release, data with no os_start passes through with sym_count=0 and ts_flag=0.

Source files
------------

// File: rtl/pcie_os_pkg.sv
// rtl/pcie_os_pkg.sv - ordered-set types and symbol constants shared by the TX lane stages
package pcie_os_pkg;

  localparam int OS_LEN = 16;

  localparam logic [7:0] TS1_ID   = 8'h4A;
  localparam logic [7:0] TS2_ID   = 8'h45;
  localparam logic [7:0] DCB_LOW  = 8'h20;
  localparam logic [7:0] DCB_HIGH = 8'hDF;

  typedef enum logic [1:0] {
    NON_TS = 2'b00,
    TS1    = 2'b01,
    TS2    = 2'b10
  } ts_type_e;

  typedef enum logic [1:0] {
    DCB_LOW_C  = 2'b00,
    DCB_HIGH_C = 2'b01,
    DCB_NORM_C = 2'b10
  } dcb_code_e;

  typedef enum logic [1:0] {
    IDLE    = 2'b00,
    TS_BODY = 2'b01,
    OS_BODY = 2'b10
  } os_state_e;

  // Reserved encoding 11 is folded into a plain (non-TS) ordered set.
  function automatic ts_type_e decode_ts_type(input logic [1:0] raw);
    case (raw)
      2'b01:   return TS1;
      2'b10:   return TS2;
      default: return NON_TS;
    endcase
  endfunction

endpackage

// File: rtl/ts_dc_symbol_inserter_if.sv
// rtl/ts_dc_symbol_inserter_if.sv - scrambler-side, tracker-side and serializer-side signals of the inserter
interface ts_dc_symbol_inserter_if #(
  parameter int DATA_WIDTH  = 8,
  parameter int COUNT_WIDTH = 4
);
  logic [DATA_WIDTH-1:0]  sc_data_in;
  logic                   sc_valid;
  logic                   os_start;
  logic [1:0]             ts_type;
  logic [1:0]             symb_14_code;
  logic [1:0]             symb_15_code;
  logic [COUNT_WIDTH-1:0] sym_count;
  logic                   ts_flag;
  logic [DATA_WIDTH-1:0]  data_out;
  logic                   data_out_valid;
  logic                   os_done;
  logic                   os_err;

  modport master (
    output sc_data_in, sc_valid, os_start, ts_type, symb_14_code, symb_15_code,
    input  sym_count, ts_flag, data_out, data_out_valid, os_done, os_err
  );

  modport slave (
    input  sc_data_in, sc_valid, os_start, ts_type, symb_14_code, symb_15_code,
    output sym_count, ts_flag, data_out, data_out_valid, os_done, os_err
  );
endinterface

// File: rtl/ts_dc_symbol_inserter_counter.sv
// rtl/ts_dc_symbol_inserter_counter.sv - ordered-set FSM and symbol index tracker
module os_symbol_counter
  import pcie_os_pkg::*;
#(
  parameter int COUNT_WIDTH = 4,
  parameter int OS_LEN_P    = 16
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   sc_valid,
  input  logic                   os_start,
  input  logic [1:0]             ts_type,
  output logic [COUNT_WIDTH-1:0] sym_count,
  output logic                   ts_flag,
  output logic                   os_err,
  output ts_type_e               ts_type_q,
  output logic                   sub_14,
  output logic                   sub_15,
  output logic                   last_sym
);

  localparam logic [COUNT_WIDTH-1:0] LAST_IDX = COUNT_WIDTH'(OS_LEN_P - 1);
  localparam logic [COUNT_WIDTH-1:0] IDX_14   = COUNT_WIDTH'(OS_LEN_P - 2);

  os_state_e              state;
  logic [COUNT_WIDTH-1:0] index;
  logic                   start_now;
  logic                   in_body;

  assign start_now = sc_valid && os_start;
  assign in_body   = (state != IDLE);

  // A new OS start always reports index 0, even when it abandons a running OS.
  assign sym_count = start_now ? '0 : index;
  assign ts_flag   = (state == TS_BODY) ||
                     (start_now && (decode_ts_type(ts_type) != NON_TS));

  assign sub_14   = sc_valid && !os_start && (state == TS_BODY) && (index == IDX_14);
  assign sub_15   = sc_valid && !os_start && (state == TS_BODY) && (index == LAST_IDX);
  assign last_sym = sc_valid && !os_start && in_body && (index == LAST_IDX);

  // Ordered-set state machine; only valid symbols advance it.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= IDLE;
      index     <= '0;
      ts_type_q <= NON_TS;
      os_err    <= 1'b0;
    end else begin
      os_err <= 1'b0;
      if (start_now) begin
        os_err    <= in_body;
        index     <= COUNT_WIDTH'(1);
        ts_type_q <= decode_ts_type(ts_type);
        state     <= (decode_ts_type(ts_type) != NON_TS) ? TS_BODY : OS_BODY;
      end else if (sc_valid && in_body) begin
        if (index == LAST_IDX) begin
          state <= IDLE;
          index <= '0;
        end else begin
          index <= index + 1'b1;
        end
      end
    end
  end

endmodule

// File: rtl/ts_dc_symbol_inserter.sv
// rtl/ts_dc_symbol_inserter.sv - TS symbol 14/15 DC-balance substitution with registered output
module ts_dc_symbol_inserter #(
  parameter int                    DATA_WIDTH  = 8,
  parameter int                    COUNT_WIDTH = 4,
  parameter int                    OS_LEN      = pcie_os_pkg::OS_LEN,
  parameter logic [DATA_WIDTH-1:0] TS1_ID      = pcie_os_pkg::TS1_ID,
  parameter logic [DATA_WIDTH-1:0] TS2_ID      = pcie_os_pkg::TS2_ID,
  parameter logic [DATA_WIDTH-1:0] DCB_LOW     = pcie_os_pkg::DCB_LOW,
  parameter logic [DATA_WIDTH-1:0] DCB_HIGH    = pcie_os_pkg::DCB_HIGH
) (
  input logic                     clk,
  input logic                     rst,
  ts_dc_symbol_inserter_if.slave  bus
);
  import pcie_os_pkg::*;

  ts_type_e              ts_type_q;
  logic                  sub_14;
  logic                  sub_15;
  logic                  last_sym;
  logic [1:0]            dcb_code;
  logic [DATA_WIDTH-1:0] sub_sym;

  os_symbol_counter #(
    .COUNT_WIDTH (COUNT_WIDTH),
    .OS_LEN_P    (OS_LEN)
  ) u_counter (
    .clk       (clk),
    .rst       (rst),
    .sc_valid  (bus.sc_valid),
    .os_start  (bus.os_start),
    .ts_type   (bus.ts_type),
    .sym_count (bus.sym_count),
    .ts_flag   (bus.ts_flag),
    .os_err    (bus.os_err),
    .ts_type_q (ts_type_q),
    .sub_14    (sub_14),
    .sub_15    (sub_15),
    .last_sym  (last_sym)
  );

  // Pick the DC-balance symbol for TS symbol 14 or 15; normal code falls back to the TS identifier.
  always_comb begin
    dcb_code = sub_14 ? bus.symb_14_code : bus.symb_15_code;
    sub_sym  = (ts_type_q == TS2) ? TS2_ID : TS1_ID;
    case (dcb_code)
      DCB_LOW_C:  sub_sym = DCB_LOW;
      DCB_HIGH_C: sub_sym = DCB_HIGH;
      default:    sub_sym = (ts_type_q == TS2) ? TS2_ID : TS1_ID;
    endcase
  end

  // One-cycle output register toward the serializer.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      bus.data_out       <= '0;
      bus.data_out_valid <= 1'b0;
      bus.os_done        <= 1'b0;
    end else begin
      bus.data_out_valid <= bus.sc_valid;
      bus.os_done        <= last_sym;
      if (bus.sc_valid) begin
        bus.data_out <= (sub_14 || sub_15) ? sub_sym : bus.sc_data_in;
      end
    end
  end

endmodule

// File: tb/tb_ts_dc_symbol_inserter.sv
// tb/tb_ts_dc_symbol_inserter.sv - scoreboard bench for the TS DC-balance symbol inserter
module tb_ts_dc_symbol_inserter;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  ts_dc_symbol_inserter_if bus ();

  ts_dc_symbol_inserter dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  typedef struct packed {
    logic [7:0] data;
    logic       done;
    logic       err;
  } exp_t;

  exp_t exp_q[$];
  exp_t mon_e;
  int   checks = 0;
  int   errors = 0;
  logic prev_valid = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Drive one valid symbol, check the tracker-facing outputs, queue the expected output.
  task automatic send(input logic [7:0] d, input logic st, input logic [1:0] tt,
                      input logic [1:0] c14, input logic [1:0] c15,
                      input logic [7:0] ed, input logic edone, input logic eerr,
                      input logic [3:0] ecnt, input logic eflag);
    @(posedge clk);
    #1;
    check("data_out_valid", 32'(bus.data_out_valid), 32'(prev_valid));
    bus.sc_data_in   = d;
    bus.sc_valid     = 1'b1;
    bus.os_start     = st;
    bus.ts_type      = tt;
    bus.symb_14_code = c14;
    bus.symb_15_code = c15;
    #1;
    check("sym_count", 32'(bus.sym_count), 32'(ecnt));
    check("ts_flag", 32'(bus.ts_flag), 32'(eflag));
    exp_q.push_back('{data: ed, done: edone, err: eerr});
    prev_valid = 1'b1;
  endtask

  task automatic idle();
    @(posedge clk);
    #1;
    check("data_out_valid", 32'(bus.data_out_valid), 32'(prev_valid));
    bus.sc_valid = 1'b0;
    bus.os_start = 1'b0;
    prev_valid   = 1'b0;
  endtask

  // Monitor: pop one expectation for every presented output symbol.
  always @(negedge clk) begin
    if (rst) begin
      if (bus.data_out_valid) begin
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_output: got %0h expected none", bus.data_out);
        end else begin
          mon_e = exp_q.pop_front();
          check("data_out", 32'(bus.data_out), 32'(mon_e.data));
          check("os_done", 32'(bus.os_done), 32'(mon_e.done));
          check("os_err", 32'(bus.os_err), 32'(mon_e.err));
        end
      end else begin
        check("os_done_idle", 32'(bus.os_done), 32'd0);
        check("os_err_idle", 32'(bus.os_err), 32'd0);
      end
    end
  end

  initial begin
    bus.sc_data_in   = 8'h00;
    bus.sc_valid     = 1'b0;
    bus.os_start     = 1'b0;
    bus.ts_type      = 2'b00;
    bus.symb_14_code = 2'b10;
    bus.symb_15_code = 2'b10;
    #1;
    check("rst_data_out", 32'(bus.data_out), 32'd0);
    check("rst_valid", 32'(bus.data_out_valid), 32'd0);
    check("rst_os_done", 32'(bus.os_done), 32'd0);
    check("rst_os_err", 32'(bus.os_err), 32'd0);
    check("rst_sym_count", 32'(bus.sym_count), 32'd0);
    check("rst_ts_flag", 32'(bus.ts_flag), 32'd0);
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst = 1'b1;

    // TS1 with normal codes: symbols 14/15 become 4Ah.
    for (int i = 0; i < 16; i++)
      send(8'(i), i == 0, 2'b01, 2'b10, 2'b10,
           (i < 14) ? 8'(i) : 8'h4A, i == 15, 1'b0, 4'(i), 1'b1);

    // TS2 with low/high codes.
    for (int i = 0; i < 16; i++)
      send(8'(i), i == 0, 2'b10, 2'b00, 2'b01,
           (i == 14) ? 8'h20 : (i == 15) ? 8'hDF : 8'(i), i == 15, 1'b0, 4'(i), 1'b1);

    // Non-TS ordered set: no substitution even with low codes.
    for (int i = 0; i < 16; i++)
      send((i >= 14) ? 8'hAA : 8'(8'h10 + i), i == 0, 2'b00, 2'b00, 2'b00,
           (i >= 14) ? 8'hAA : 8'(8'h10 + i), i == 15, 1'b0, 4'(i), 1'b0);

    // TS1 with a three-cycle valid gap after symbol 7.
    for (int i = 0; i < 8; i++)
      send(8'(8'h80 + i), i == 0, 2'b01, 2'b01, 2'b00,
           8'(8'h80 + i), 1'b0, 1'b0, 4'(i), 1'b1);
    repeat (3) idle();
    for (int i = 8; i < 16; i++)
      send(8'(8'h80 + i), 1'b0, 2'b01, 2'b01, 2'b00,
           (i == 14) ? 8'hDF : (i == 15) ? 8'h20 : 8'(8'h80 + i), i == 15, 1'b0, 4'(i), 1'b1);

    // Restart at index 9 of a TS1.
    for (int i = 0; i < 9; i++)
      send(8'(8'h90 + i), i == 0, 2'b01, 2'b10, 2'b10,
           8'(8'h90 + i), 1'b0, 1'b0, 4'(i), 1'b1);
    send(8'h99, 1'b1, 2'b01, 2'b10, 2'b10, 8'h99, 1'b0, 1'b1, 4'd0, 1'b1);
    for (int j = 1; j < 16; j++)
      send(8'(8'hA0 + j), 1'b0, 2'b01, 2'b10, 2'b10,
           (j >= 14) ? 8'h4A : 8'(8'hA0 + j), j == 15, 1'b0, 4'(j), 1'b1);

    // Reset in the middle of a TS1 at index 12.
    for (int i = 0; i < 12; i++)
      send(8'(8'hC0 + i), i == 0, 2'b01, 2'b10, 2'b10,
           8'(8'hC0 + i), 1'b0, 1'b0, 4'(i), 1'b1);
    idle();
    @(posedge clk);
    #1;
    check("pre_rst_sym_count", 32'(bus.sym_count), 32'd12);
    rst = 1'b0;
    #1;
    check("mid_rst_data_out", 32'(bus.data_out), 32'd0);
    check("mid_rst_valid", 32'(bus.data_out_valid), 32'd0);
    check("mid_rst_sym_count", 32'(bus.sym_count), 32'd0);
    check("mid_rst_ts_flag", 32'(bus.ts_flag), 32'd0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    send(8'h33, 1'b0, 2'b01, 2'b10, 2'b10, 8'h33, 1'b0, 1'b0, 4'd0, 1'b0);
    send(8'h34, 1'b0, 2'b10, 2'b00, 2'b01, 8'h34, 1'b0, 1'b0, 4'd0, 1'b0);
    idle();
    idle();
    idle();

    check("queue_empty", 32'(exp_q.size()), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
